cmp_window_stat: RTL and testbench

CMP_WINDOW_STAT -- requirements
Module: cmp_window_stat

---
 rtl/cmp_pkg.sv | 15 +
 rtl/cmp_window_stat_if.sv | 37 +++
 rtl/cmp_core.sv | 18 +
 rtl/cmp_window_stat.sv | 99 +++++++++
 tb/tb_cmp_window_stat.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the windowed comparator statistics block.
package cmp_pkg;

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    EQ = 2'd0,
    GT = 2'd1,
    LT = 2'd2
  } cmp_res_t;

endpackage

// File: rtl/cmp_window_stat_if.sv
// Sample/report handshake bundle for cmp_window_stat.
// eq_streak exists only when CMP_STREAK_EN is defined.
interface cmp_window_stat_if #(
  parameter int WIDTH = 4,
  parameter int CW    = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    eq_cnt;
  logic [CW-1:0]    gt_cnt;
  logic [CW-1:0]    lt_cnt;
`ifdef CMP_STREAK_EN
  logic [CW-1:0]    eq_streak;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, eq_cnt, gt_cnt, lt_cnt, eq_streak
  );
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, eq_cnt, gt_cnt, lt_cnt, eq_streak
  );
`else
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, eq_cnt, gt_cnt, lt_cnt
  );
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, eq_cnt, gt_cnt, lt_cnt
  );
`endif
endinterface

// File: rtl/cmp_core.sv
// Combinational unsigned 3-way compare of a against b.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_res_t         res
);

  always_comb begin
    res = EQ;
    if (a > b)      res = GT;
    else if (a < b) res = LT;
  end

endmodule

// File: rtl/cmp_window_stat.sv
// Counts eq/gt/lt outcomes over WINDOW accepted samples, then holds a report.
// Optional longest-eq-run tracking is enabled by defining CMP_STREAK_EN.
//
// state  | meaning
// ACCUM  | accepting samples, counts track the partial window
// REPORT | window complete, counts held until out_ready
module cmp_window_stat
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 8,
  localparam int CW    = $clog2(WINDOW + 1)
) (
  input  logic               clk,
  input  logic               rst,
  cmp_window_stat_if.slave   bus
);

  state_t        state_q, state_d;
  cmp_res_t      res;
  logic [CW-1:0] eq_q, gt_q, lt_q, smp_q;
  logic          accept, handshake, last_smp;

  cmp_core #(.WIDTH(WIDTH)) u_cmp (
    .a   (bus.a),
    .b   (bus.b),
    .res (res)
  );

  assign accept    = (state_q == ACCUM) && bus.in_valid;
  assign handshake = (state_q == REPORT) && bus.out_ready;
  assign last_smp  = (smp_q == CW'(WINDOW - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && last_smp) state_d = REPORT;
      end
      REPORT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || handshake) begin
      eq_q  <= '0;
      gt_q  <= '0;
      lt_q  <= '0;
      smp_q <= '0;
    end else if (accept) begin
      smp_q <= smp_q + 1'b1;
      case (res)
        EQ:      eq_q <= eq_q + 1'b1;
        GT:      gt_q <= gt_q + 1'b1;
        default: lt_q <= lt_q + 1'b1;
      endcase
    end
  end

  assign bus.eq_cnt = eq_q;
  assign bus.gt_cnt = gt_q;
  assign bus.lt_cnt = lt_q;

`ifdef CMP_STREAK_EN
  logic [CW-1:0] run_q, streak_q, run_inc;

  assign run_inc = run_q + 1'b1;

  // The max uses the incremented run so the streak is current in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || handshake) begin
      run_q    <= '0;
      streak_q <= '0;
    end else if (accept) begin
      if (res == EQ) begin
        run_q <= run_inc;
        if (run_inc > streak_q) streak_q <= run_inc;
      end else begin
        run_q <= '0;
      end
    end
  end

  assign bus.eq_streak = streak_q;
`endif

endmodule

// File: tb/tb_cmp_window_stat.sv
// Directed self-checking bench for cmp_window_stat (WIDTH=4, WINDOW=8).
module tb_cmp_window_stat;

  localparam int WIDTH  = 4;
  localparam int WINDOW = 8;
  localparam int CW     = $clog2(WINDOW + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cmp_window_stat_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  cmp_window_stat #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int av, input int bv);
    bus.in_valid = 1'b1;
    bus.a        = WIDTH'(av);
    bus.b        = WIDTH'(bv);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_report(input string tag);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_report_seen"}, int'(bus.out_valid === 1'b1), 1);
  endtask

  task automatic counts(input string tag, input int e, input int g, input int l);
    chk({tag, "_eq"}, int'(bus.eq_cnt), e);
    chk({tag, "_gt"}, int'(bus.gt_cnt), g);
    chk({tag, "_lt"}, int'(bus.lt_cnt), l);
  endtask

  task automatic streak(input string tag, input int s);
`ifdef CMP_STREAK_EN
    chk({tag, "_streak"}, int'(bus.eq_streak), s);
`else
    if (s < 0) $display("unused streak %s", tag);
`endif
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_hs_ovalid"}, int'(bus.out_valid), 0);
    chk({tag, "_hs_iready"}, int'(bus.in_ready), 1);
    counts({tag, "_hs"}, 0, 0, 0);
    streak({tag, "_hs"}, 0);
  endtask

  int va [8] = '{9, 2, 4, 15, 0, 6, 6, 1};
  int vb [8] = '{3, 7, 4, 0, 15, 6, 6, 1};

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ovalid", int'(bus.out_valid), 0);
    chk("rst_iready", int'(bus.in_ready), 1);
    counts("rst", 0, 0, 0);
    streak("rst", 0);

    // all-equal window
    for (int i = 0; i < 7; i++) push(5, 5);
    chk("eq7_ovalid", int'(bus.out_valid), 0);
    chk("eq7_eq", int'(bus.eq_cnt), 7);
    push(5, 5);
    chk("eq8_ovalid", int'(bus.out_valid), 1);
    counts("eq8", 8, 0, 0);
    streak("eq8", 8);
    handshake("eq8");

    // mixed window
    for (int i = 0; i < 8; i++) push(va[i], vb[i]);
    wait_report("mix");
    counts("mix", 4, 2, 2);
    streak("mix", 3);

    // backpressure: report held, input ignored
    bus.in_valid = 1'b1;
    bus.a        = 4'd7;
    bus.b        = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_iready", int'(bus.in_ready), 0);
      chk("bp_ovalid", int'(bus.out_valid), 1);
      counts("bp", 4, 2, 2);
    end
    bus.in_valid = 1'b0;
    handshake("bp");

    // gapped input
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.a        = 4'd8;
      bus.b        = 4'd2;
      @(negedge clk);
      if (i == 13) begin
        chk("gap7_ovalid", int'(bus.out_valid), 0);
        chk("gap7_gt", int'(bus.gt_cnt), 7);
      end
    end
    bus.in_valid = 1'b0;
    chk("gap_ovalid", int'(bus.out_valid), 1);
    counts("gap", 0, 8, 0);
    handshake("gap");

    // reset mid-window discards partial counts
    for (int i = 0; i < 5; i++) push(9, 9);
    chk("pre_rst_eq", int'(bus.eq_cnt), 5);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.a        = 4'd9;
    bus.b        = 4'd9;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    counts("midrst", 0, 0, 0);
    streak("midrst", 0);
    for (int i = 0; i < 7; i++) push(3, 10);
    chk("lt7_ovalid", int'(bus.out_valid), 0);
    push(3, 10);
    wait_report("lt");
    counts("lt", 0, 0, 8);
    streak("lt", 0);

    // reset concurrent with handshake
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b0;
    chk("rsths_ovalid", int'(bus.out_valid), 0);
    chk("rsths_iready", int'(bus.in_ready), 1);
    counts("rsths", 0, 0, 0);
    streak("rsths", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
